exe_muldiv_unit: RTL and testbench
==================================

Name: exe_muldiv_unit

Overview:
Iterative multiply/divide unit for the EXE stage of the 5-stage MIPS pipeline. Implements MULT, MULTU, DIV, DIVU, MTHI and MTLO with architectural HI/LO registers, parametrised in data width. Stalls the pipeline through `busy` while an operation is in flight. Pipeline control can abort an operation with `flush`.

Parameters:
- DATA_W, 32, operand/HI/LO width; must be even and ≥ 8.
- CNT_W, $clog2(DATA_W)+1, iteration counter width (derived, not overridden).

Ports:
- clk  in  1  main clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  operation request from ID/EXE; accepted only when state = IDLE.
- oper  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 ignored (no action).
- opa  in  DATA_W  rs operand, sampled on the accepting edge.
- opb  in  DATA_W  rt operand, sampled on the accepting edge.
- flush  in  1  abort in-flight operation (branch/exception squash).
- busy  out  1  registered; high while state ≠ IDLE; drives the EXE stall.
- done  out  1  registered one-cycle pulse when HI/LO commit from MULT/DIV.
- div_by_zero  out  1  registered; valid with done; high for DIV/DIVU with opb = 0.
- hi  out  DATA_W  HI register.
- lo  out  DATA_W  LO register.

Behaviour:
- Reset (rst_n = 0 at posedge): state IDLE; hi = lo = 0; busy = done = div_by_zero = 0; counter = 0. Reset mid-operation abandons the operation; HI/LO still clear.
- States: IDLE → CALC → FIX → IDLE.
  - IDLE, start & ~flush, oper ∈ {0..3}:
    - latch |opa|, |opb| (signed ops) or raw values (unsigned ops);
    - record result signs;
    - counter = DATA_W; busy = 1 next cycle.
  - IDLE, start, oper = 4/5: hi (resp. lo) = opa at that edge; no busy; done stays 0.
  - CALC: one radix-2 step per cycle.
    - Multiply: shift-add, 2·DATA_W product register.
    - Divide: restoring divide, remainder/quotient registers.
    - Counter decrements each step; at counter = 1 → FIX.
  - FIX: negate product when signs differ. For division, quotient sign = sign(opa) XOR sign(opb) and remainder sign = sign(opa). Next edge:
    - MULT/MULTU: hi = product upper half, lo = product lower half;
    - DIV/DIVU: hi = remainder, lo = quotient;
    - done = 1 for one cycle; busy = 0; → IDLE.
- Latency: start sampled at edge E. HI/LO updated and done high after edge E+DATA_W+1, i.e. DATA_W+2 cycles (34 for DATA_W = 32). busy is high for exactly DATA_W+1 cycles.
- start while busy: ignored; upstream must hold it.
- Divide by zero: hi = opa (dividend, unmodified), lo = all ones, div_by_zero = 1 with done. Latency is unchanged.
- Signed overflow, DIV of -2^(DATA_W-1) by -1: lo = -2^(DATA_W-1), hi = 0. This is natural wrap, not flagged.
- flush:
  - In CALC/FIX: → IDLE next edge; busy = 0; done = 0; HI/LO keep prior values.
  - In IDLE: blocks a same-cycle start, including MTHI/MTLO.
  - flush and the FIX commit edge coincide: flush wins, no commit.
- HI/LO are never partially updated; commit is atomic at FIX exit.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined, multiply: CALC exits to FIX as soon as the remaining multiplier bits are all zero.
- Defined, divide: when |opa| < |opb| at acceptance, the unit goes directly to FIX with quotient 0 and remainder |opa|.
- Defined: latency is variable, minimum 2 cycles (accept edge → FIX → commit); the done/busy rules above are unchanged.
- Undefined: fixed DATA_W+2 latency for all MULT/DIV operations.

Decomposition:
- Shared package muldiv_pkg:
  - oper encodings OP_MULT … OP_MTLO;
  - state enum ST_IDLE/ST_CALC/ST_FIX;
  - default DATA_W constant.
- One natural sub-module, muldiv_sign_fix: combinational two's-complement conditional negate, used for the operand abs values and the result fixup.

Test Plan:
- MULT opa = 7, opb = -3 (DATA_W = 32) → 34 cycles later done = 1, hi = FFFF_FFFF, lo = FFFF_FFEB; busy high for exactly 33 cycles.
- DIVU opa = 100, opb = 7 → lo = 14, hi = 2. Then DIV opa = -7, opb = 2 → lo = FFFF_FFFD, hi = FFFF_FFFF.
- DIV opa = 5, opb = 0 → done with div_by_zero = 1, hi = 5, lo = FFFF_FFFF. Next MULTU 3×4 → div_by_zero = 0, hi = 0, lo = 12.
- MTHI opa = DEAD_BEEF, then start MULT at the same edge as the 5th CALC cycle of a prior op → hi = DEAD_BEEF immediately; second start ignored; busy unaffected by MTHI.
- MULTU in flight, flush pulsed in cycle 10 → busy = 0 next cycle, no done, hi/lo unchanged. Also flush asserted on the FIX cycle → no commit.
- Macro defined: MULTU opa = 9, opb = 1 → done 3 cycles after acceptance, lo = 9. DIVU 3/10 → done after 2 cycles, lo = 0, hi = 3. Macro undefined: same operations take 34 cycles.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the EXE-stage multiply/divide unit: opcodes, FSM states and
// per-operation sign/flag bundle latched on acceptance.
package muldiv_pkg;

  localparam int MULDIV_DATA_W = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  // neg_lo: negate product (mult) or quotient (div); neg_rem: negate remainder
  typedef struct packed {
    logic is_div;
    logic neg_lo;
    logic neg_rem;
    logic dbz;
  } op_info_t;

endpackage

// File: rtl/exe_muldiv_unit_if.sv
// Pipeline-side bundle of the multiply/divide unit: request from ID/EXE, squash,
// stall and the architectural HI/LO view.
interface exe_muldiv_unit_if
  import muldiv_pkg::*;
#(
  parameter int DATA_W = MULDIV_DATA_W
);
  logic              start;
  logic [2:0]        oper;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic              flush;
  logic              busy;
  logic              done;
  logic              div_by_zero;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output start, oper, opa, opb, flush,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, oper, opa, opb, flush,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate; purely combinational, no backpressure.
// Used for operand magnitudes and for the final product/quotient/remainder signs.
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] din,
  input  logic         neg,
  output logic [W-1:0] dout
);
  assign dout = neg ? -din : din;
endmodule

// File: rtl/exe_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO and MTHI/MTLO; MULDIV_EARLY_OUT_EN enables early exit.
// Done DATA_W+2 cycles after the accepting edge (shorter with early exit); busy stalls EXE, start ignored while busy.
module exe_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_W = MULDIV_DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  exe_muldiv_unit_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam int PW    = 2 * DATA_W;

  logic [1:0]        state, state_nxt;
  logic              busy_q, done_q, dbz_q;
  logic [DATA_W-1:0] hi_q, lo_q;
  logic [CNT_W-1:0]  cnt;
  logic [PW-1:0]     acc;     // product, or {remainder, quotient}
  logic [PW-1:0]     mcand;   // shifted multiplicand; divisor sits in the low half
  logic [DATA_W-1:0] mplier;
  op_info_t          info;

  logic              accept, op_muldiv, op_div, op_signed;
  logic              sign_a, sign_b, div_short, calc_last, commit;
  logic [DATA_W-1:0] abs_a, abs_b;
  logic [PW-1:0]     prod_fix;
  logic [DATA_W-1:0] quo_fix, rem_fix, res_hi, res_lo;

  assign accept    = (state == ST_IDLE) && bus.start && !bus.flush;
  assign op_muldiv = !bus.oper[2];
  assign op_div    = op_muldiv && bus.oper[1];
  assign op_signed = (bus.oper == OP_MULT) || (bus.oper == OP_DIV);
  assign sign_a    = op_signed && bus.opa[DATA_W-1];
  assign sign_b    = op_signed && bus.opb[DATA_W-1];

  muldiv_sign_fix #(.W(DATA_W)) u_abs_a (.din(bus.opa), .neg(sign_a), .dout(abs_a));
  muldiv_sign_fix #(.W(DATA_W)) u_abs_b (.din(bus.opb), .neg(sign_b), .dout(abs_b));

  muldiv_sign_fix #(.W(PW)) u_fix_prod (
    .din (acc),
    .neg (info.neg_lo),
    .dout(prod_fix)
  );
  muldiv_sign_fix #(.W(DATA_W)) u_fix_quo (
    .din (acc[DATA_W-1:0]),
    .neg (info.neg_lo),
    .dout(quo_fix)
  );
  muldiv_sign_fix #(.W(DATA_W)) u_fix_rem (
    .din (acc[PW-1:DATA_W]),
    .neg (info.neg_rem),
    .dout(rem_fix)
  );

  // One radix-2 step: shift-add multiply or restoring divide
  logic [DATA_W:0]   rem_sh;
  logic [DATA_W-1:0] sub_lo;
  logic              sub_ok;
  logic [PW-1:0]     mul_nxt, div_nxt;

  always_comb begin
    rem_sh  = {acc[PW-1:DATA_W], acc[DATA_W-1]};
    sub_ok  = rem_sh >= {1'b0, mcand[DATA_W-1:0]};
    sub_lo  = rem_sh[DATA_W-1:0] - mcand[DATA_W-1:0];
    div_nxt = sub_ok ? {sub_lo, acc[DATA_W-2:0], 1'b1}
                     : {rem_sh[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
    mul_nxt = mplier[0] ? acc + mcand : acc;
  end

`ifdef MULDIV_EARLY_OUT_EN
  assign div_short = op_div && (abs_a < abs_b);
  assign calc_last = (cnt == CNT_W'(1)) ||
                     (!info.is_div && (mplier[DATA_W-1:1] == '0));
`else
  assign div_short = 1'b0;
  assign calc_last = (cnt == CNT_W'(1));
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept && op_muldiv) state_nxt = div_short ? ST_FIX : ST_CALC;
      ST_CALC: state_nxt = bus.flush ? ST_IDLE : (calc_last ? ST_FIX : ST_CALC);
      ST_FIX:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A flush on the FIX cycle suppresses the commit entirely
  assign commit = (state == ST_FIX) && !bus.flush;
  assign res_hi = info.is_div ? rem_fix : prod_fix[PW-1:DATA_W];
  assign res_lo = !info.is_div ? prod_fix[DATA_W-1:0] : (info.dbz ? '1 : quo_fix);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      info   <= '0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt != ST_IDLE);
      done_q <= commit;
      dbz_q  <= commit && info.dbz;

      if (commit) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
      if (accept && bus.oper == OP_MTHI) hi_q <= bus.opa;
      if (accept && bus.oper == OP_MTLO) lo_q <= bus.opa;

      if (accept && op_muldiv) begin
        cnt          <= CNT_W'(DATA_W);
        info.is_div  <= op_div;
        info.neg_lo  <= sign_a ^ sign_b;
        info.neg_rem <= sign_a;
        info.dbz     <= op_div && (bus.opb == '0);
        mplier       <= abs_b;
        mcand        <= {{DATA_W{1'b0}}, (op_div ? abs_b : abs_a)};
        if (!op_div)        acc <= '0;
        else if (div_short) acc <= {abs_a, {DATA_W{1'b0}}};
        else                acc <= {{DATA_W{1'b0}}, abs_a};
      end else if (state == ST_CALC) begin
        cnt <= cnt - CNT_W'(1);
        if (info.is_div) begin
          acc <= div_nxt;
        end else begin
          acc    <= mul_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
        end
      end
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Scoreboard bench for exe_muldiv_unit: directed vectors push expected HI/LO/flag/latency,
// a negedge monitor pops and compares on every done pulse.
module tb_exe_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W    = 32;
  localparam int FULL = W + 1;   // edges from accept to commit without early exit
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           due;
  } exp_t;

  exp_t sb[$];

  logic clk = 1'b0;
  logic rst_n;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  exe_muldiv_unit_if #(.DATA_W(W)) bus ();
  exe_muldiv_unit #(.DATA_W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected none pending", cyc);
      end else begin
        e = sb.pop_front();
        chk("done_hi", bus.hi, e.hi);
        chk("done_lo", bus.lo, e.lo);
        chk("done_dbz", bus.div_by_zero, e.dbz);
        chk("done_latency", cyc, e.due);
      end
    end
  end

  // Called at a negedge; returns at the negedge following the accepting edge
  task automatic drive(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1;
    bus.oper  = op;
    bus.opa   = a;
    bus.opb   = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) chk(name, bus.busy, 0);
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edbz,
                       input int lat);
    exp_t e;
    int   n;
    e.hi  = ehi;
    e.lo  = elo;
    e.dbz = edbz;
    e.due = cyc + 1 + lat;
    sb.push_back(e);
    drive(op, a, b);
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("busy_cycles", n, lat);
    @(negedge clk);
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.oper  = 3'd0;
    bus.opa   = '0;
    bus.opb   = '0;
    bus.flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_dbz", bus.div_by_zero, 0);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Arithmetic vectors
    issue(OP_MULT,  32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, EARLY ? 3 : FULL);
    issue(OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0, FULL);
    issue(OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, FULL);
    issue(OP_DIV,   32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1, FULL);
    issue(OP_MULTU, 32'd3,         32'd4,         32'd0,         32'd12,        1'b0, EARLY ? 4 : FULL);
    issue(OP_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, FULL);
    issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, FULL);
    issue(OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0, FULL);
    issue(OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         1'b0, FULL);
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1,         1'b0, FULL);
    issue(OP_MULTU, 32'd9,         32'd1,         32'd0,         32'd9,         1'b0, EARLY ? 2 : FULL);
    issue(OP_DIVU,  32'd3,         32'd10,        32'd3,         32'd0,         1'b0, EARLY ? 1 : FULL);

    // MTHI/MTLO write immediately, never raise busy
    drive(OP_MTHI, 32'hDEAD_BEEF, 32'd0);
    chk("mthi_hi", bus.hi, 32'hDEAD_BEEF);
    chk("mthi_busy", bus.busy, 0);
    chk("mthi_lo_kept", bus.lo, 32'd0);
    drive(OP_MTLO, 32'h1234_5678, 32'd0);
    chk("mtlo_lo", bus.lo, 32'h1234_5678);
    chk("mtlo_hi_kept", bus.hi, 32'hDEAD_BEEF);
    bus.flush = 1'b1;
    drive(OP_MTHI, 32'h0BAD_F00D, 32'd0);
    bus.flush = 1'b0;
    chk("flush_blocks_mthi", bus.hi, 32'hDEAD_BEEF);
    drive(3'd6, 32'h1111_1111, 32'h2222_2222);
    chk("oper6_busy", bus.busy, 0);
    chk("oper6_hi", bus.hi, 32'hDEAD_BEEF);
    chk("oper6_lo", bus.lo, 32'h1234_5678);

    // A start on the 5th CALC cycle of an op in flight is dropped
    begin
      exp_t e;
      e.hi  = 32'd1;
      e.lo  = 32'd0;
      e.dbz = 1'b0;
      e.due = cyc + 1 + FULL;
      sb.push_back(e);
      drive(OP_MULTU, 32'd2, 32'h8000_0000);
      repeat (4) @(negedge clk);
      drive(OP_MULT, 32'd11, 32'd13);
      chk("busy_during_second_start", bus.busy, 1);
      wait_idle("ignored_start_timeout");
      repeat (3) @(negedge clk);
      chk("ignored_start_busy", bus.busy, 0);
      chk("ignored_start_sb", sb.size(), 0);
    end

    // Flush in the 10th busy cycle: no done, HI/LO kept
    drive(OP_MULTU, 32'h0001_2345, 32'h8000_0000);
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_calc_busy", bus.busy, 0);
    chk("flush_calc_done", bus.done, 0);
    repeat (40) @(negedge clk);
    chk("flush_calc_hi", bus.hi, 32'd1);
    chk("flush_calc_lo", bus.lo, 32'd0);

    // Flush on the FIX cycle beats the commit
    drive(OP_MULTU, 32'd5, 32'd6);
    repeat ((EARLY ? 4 : FULL) - 1) @(negedge clk);
    chk("fix_cycle_busy", bus.busy, 1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_fix_busy", bus.busy, 0);
    chk("flush_fix_done", bus.done, 0);
    repeat (5) @(negedge clk);
    chk("flush_fix_hi", bus.hi, 32'd1);
    chk("flush_fix_lo", bus.lo, 32'd0);
    issue(OP_MULTU, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, EARLY ? 4 : FULL);

    // Reset mid-operation clears HI/LO and abandons the op
    drive(OP_DIVU, 32'd1000, 32'd3);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_hi", bus.hi, 32'd0);
    chk("midrst_lo", bus.lo, 32'd0);
    chk("midrst_busy", bus.busy, 0);
    repeat (40) @(negedge clk);
    chk("midrst_idle", bus.busy, 0);

    chk("sb_empty_end", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
